// File: rtl/ea_pkg.sv
// Shared selector encodings and pipeline depth limits for the effective-address pipe.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ea_pkg;

  // Base operand select: program counter or register-file base.
  typedef enum logic {
    A1_PC   = 1'b0,
    A1_BASE = 1'b1
  } addr1_sel_e;

  // Offset select: zero or one of three sign-extended IR fields of increasing width.
  typedef enum logic [1:0] {
    A2_ZERO = 2'd0,
    A2_OFFA = 2'd1,
    A2_OFFB = 2'd2,
    A2_OFFC = 2'd3
  } addr2_sel_e;

  // Stage 0 selects/extends and stage 1 adds, so two stages are the minimum.
  localparam int EA_MIN_STAGES = 2;
  localparam int EA_MAX_STAGES = 4;

endpackage

// File: rtl/ea_stage.sv
// One valid/ready register slice carrying an opaque payload of W bits.
// Latency: 1 cycle.
// Backpressure: loads whenever empty or downstream takes the held entry, so bubbles collapse.
//
// Ports:
//   clk, reset, flush      clock, sync active-high reset, sync clear of the valid bit
//   in_vld/in_rdy/in_dat   upstream handshake; in_rdy is this slice's load enable
//   out_vld/out_rdy/out_dat downstream handshake
module ea_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic         vld_q;
  logic [W-1:0] dat_q;

  assign in_rdy  = !vld_q || out_rdy;
  assign out_vld = vld_q;
  assign out_dat = dat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      if (flush) begin
        vld_q <= 1'b0;
      end else if (in_rdy) begin
        vld_q <= in_vld;
      end
      // Data only moves with a real entry, so held outputs never glitch.
      if (in_rdy && in_vld) begin
        dat_q <= in_dat;
      end
    end
  end

endmodule

// File: rtl/ea_pipe.sv
// Pipelined effective-address generator: selected base + sign-extended IR offset, with wrap/page-cross flags.
// Latency: STAGES cycles accept-to-out_valid with out_ready high; one result per cycle.
// Backpressure: per-stage stall with bubble collapse; in_ready = stage 0 load, combinational from out_ready.
//
// Ports:
//   Clk, Reset, Flush                 clock, sync active-high reset, sync drop of all in-flight requests
//   in_valid/in_ready                 request handshake; pc, base, ir, addr1_sel, addr2_sel, in_tag are the request
//   out_valid/out_ready               result handshake; out_addr, out_wrap, out_pcross, out_tag are the result
//   done_cnt                          count of completed output transfers, wraps
module ea_pipe
  import ea_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int STAGES    = 2,
  parameter int OFF_A_W   = 6,
  parameter int OFF_B_W   = 9,
  parameter int OFF_C_W   = 11,
  parameter int PAGE_BITS = 7,
  parameter int TAG_W     = 4,
  parameter int CNT_W     = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] ir,
  input  logic              addr1_sel,
  input  logic [1:0]        addr2_sel,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_addr,
  output logic              out_wrap,
  output logic              out_pcross,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CNT_W-1:0]  done_cnt
);

  if (STAGES < EA_MIN_STAGES || STAGES > EA_MAX_STAGES) begin : g_bad_stages
    $error("ea_pipe: STAGES must be within 2..4");
  end
  if (OFF_A_W > DATA_W || OFF_B_W > DATA_W || OFF_C_W > DATA_W) begin : g_bad_off
    $error("ea_pipe: offset field wider than DATA_W");
  end
  if (PAGE_BITS < 1 || PAGE_BITS > DATA_W) begin : g_bad_page
    $error("ea_pipe: PAGE_BITS must be within 1..DATA_W");
  end

  // Stage 0 holds operands; stages 1.. hold the finished result.
  typedef struct packed {
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] off;
    logic [TAG_W-1:0]  tag;
  } opnd_t;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic              wrap;
    logic              pcross;
    logic [TAG_W-1:0]  tag;
  } res_t;

  logic [STAGES-1:0] vld;
  logic [STAGES:0]   rdy;     // rdy[k] = load enable of stage k; rdy[STAGES] = consumer
  opnd_t             s0_in;
  opnd_t             s0_q;
  res_t              res_in;
  res_t              rdat [1:STAGES-1];
  res_t              res_out;
  logic [DATA_W:0]   sum_full;
  logic              s0_vld;

  assign rdy[STAGES] = out_ready;

  // Nothing may enter on a flush or reset cycle.
  assign s0_vld   = in_valid && !Flush && !Reset;
  assign in_ready = rdy[0] && !Flush && !Reset;

  // Select base and sign-extend the chosen IR field.
  always_comb begin
    s0_in      = '0;
    s0_in.tag  = in_tag;
    s0_in.base = (addr1_sel_e'(addr1_sel) == A1_BASE) ? base : pc;
    case (addr2_sel_e'(addr2_sel))
      A2_OFFA: s0_in.off = DATA_W'($signed(ir[OFF_A_W-1:0]));
      A2_OFFB: s0_in.off = DATA_W'($signed(ir[OFF_B_W-1:0]));
      A2_OFFC: s0_in.off = DATA_W'($signed(ir[OFF_C_W-1:0]));
      default: s0_in.off = '0;
    endcase
  end

  ea_stage #(.W($bits(opnd_t))) u_stage0 (
    .clk     (Clk),
    .reset   (Reset),
    .flush   (Flush),
    .in_vld  (s0_vld),
    .in_rdy  (rdy[0]),
    .in_dat  (s0_in),
    .out_vld (vld[0]),
    .out_rdy (rdy[1]),
    .out_dat (s0_q)
  );

  // Offset is already DATA_W two's complement, so the plain unsigned carry is the wrap flag.
  assign sum_full = {1'b0, s0_q.base} + {1'b0, s0_q.off};

  always_comb begin
    res_in        = '0;
    res_in.addr   = sum_full[DATA_W-1:0];
    res_in.wrap   = sum_full[DATA_W];
    res_in.pcross = sum_full[DATA_W-1 -: PAGE_BITS] != s0_q.base[DATA_W-1 -: PAGE_BITS];
    res_in.tag    = s0_q.tag;
  end

  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    res_t d_in;
    if (k == 1) begin : g_add
      assign d_in = res_in;
    end else begin : g_dly
      assign d_in = rdat[k-1];
    end

    ea_stage #(.W($bits(res_t))) u_stage (
      .clk     (Clk),
      .reset   (Reset),
      .flush   (Flush),
      .in_vld  (vld[k-1]),
      .in_rdy  (rdy[k]),
      .in_dat  (d_in),
      .out_vld (vld[k]),
      .out_rdy (rdy[k+1]),
      .out_dat (rdat[k])
    );
  end

  assign res_out    = rdat[STAGES-1];
  assign out_valid  = vld[STAGES-1];
  assign out_addr   = res_out.addr;
  assign out_wrap   = res_out.wrap;
  assign out_pcross = res_out.pcross;
  assign out_tag    = res_out.tag;

  // Flush leaves the counter alone; a transfer on the flush cycle still counts.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      done_cnt <= '0;
    end else if (out_valid && out_ready) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ea_pipe.sv
// Bench for ea_pipe: a STAGES=2 instance and a STAGES=4/CNT_W=2 instance against a queue-based reference.
// Latency: n/a.
// Backpressure: randomized out_ready and flush; inputs held until accepted.
module tb_ea_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ordy = 1'b0;
  logic [15:0] pc = '0, base = '0, ir = '0;
  logic        a1 = 1'b0;
  logic [1:0]  a2 = '0;
  logic [3:0]  tag = '0;
  logic        iv    [2];
  logic        irdy  [2];
  logic        ov    [2];
  logic        owrap [2];
  logic        opc   [2];
  logic [15:0] oaddr [2];
  logic [3:0]  otag  [2];
  logic [15:0] dcnt0;
  logic [1:0]  dcnt1;

  always #5 clk = ~clk;

  ea_pipe dut0 (
    .Clk(clk), .Reset(rst), .Flush(flush), .in_valid(iv[0]), .in_ready(irdy[0]),
    .pc(pc), .base(base), .ir(ir), .addr1_sel(a1), .addr2_sel(a2), .in_tag(tag),
    .out_valid(ov[0]), .out_ready(ordy), .out_addr(oaddr[0]), .out_wrap(owrap[0]),
    .out_pcross(opc[0]), .out_tag(otag[0]), .done_cnt(dcnt0)
  );

  ea_pipe #(.STAGES(4), .CNT_W(2)) dut1 (
    .Clk(clk), .Reset(rst), .Flush(flush), .in_valid(iv[1]), .in_ready(irdy[1]),
    .pc(pc), .base(base), .ir(ir), .addr1_sel(a1), .addr2_sel(a2), .in_tag(tag),
    .out_valid(ov[1]), .out_ready(ordy), .out_addr(oaddr[1]), .out_wrap(owrap[1]),
    .out_pcross(opc[1]), .out_tag(otag[1]), .done_cnt(dcnt1)
  );

  typedef struct {
    logic [15:0] addr;
    logic        wrap;
    logic        pcross;
    logic [3:0]  tag;
    int          acc;
  } exp_t;

  exp_t mq [2][16];
  int   mh [2];
  int   mc [2];
  int   mdone [2];
  bit   fresh [2];
  bit   acc_f [2];
  bit   xfr_f [2];
  int   cyc_n = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc_n);
  endtask

  // Sign-extend the low w bits of i as an integer.
  function automatic int sx(input logic [15:0] i, input int w);
    int f;
    f = int'(i) % (1 << w);
    if (f >= (1 << (w - 1))) f -= (1 << w);
    return f;
  endfunction

  function automatic exp_t ref_ea(input logic [15:0] p, input logic [15:0] b, input logic [15:0] i,
                                  input logic s1, input logic [1:0] s2, input logic [3:0] t);
    exp_t e;
    int bv, offv, sum;
    bv = s1 ? int'(b) : int'(p);
    case (s2)
      2'd0:    offv = 0;
      2'd1:    offv = sx(i, 6);
      2'd2:    offv = sx(i, 9);
      default: offv = sx(i, 11);
    endcase
    if (offv < 0) offv += 65536;
    sum      = bv + offv;
    e.addr   = 16'(sum % 65536);
    e.wrap   = (sum >= 65536);
    e.pcross = ((sum % 65536) / 512) != (bv / 512);
    e.tag    = t;
    e.acc    = 0;
    return e;
  endfunction

  // One clock: check both DUTs mid-cycle against the model, update the model, return just after the edge.
  task automatic cyc();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int st, mask;
      logic e_ir, e_ov;
      logic [15:0] dc;
      exp_t h, e;
      st    = (d == 0) ? 2 : 4;
      mask  = (d == 0) ? 32'hFFFF : 32'h3;
      e_ir  = !rst && !flush && (mc[d] < st || ordy);
      h     = mq[d][mh[d]];
      // The oldest entry never waits on anything ahead of it, so it surfaces exactly st cycles after accept.
      e_ov  = (mc[d] > 0) && (cyc_n - h.acc >= st);
      check($sformatf("d%0d_in_ready", d), irdy[d], e_ir);
      check($sformatf("d%0d_out_valid", d), ov[d], e_ov);
      if (e_ov) begin
        check($sformatf("d%0d_addr", d), oaddr[d], h.addr);
        check($sformatf("d%0d_wrap", d), owrap[d], h.wrap);
        check($sformatf("d%0d_pcross", d), opc[d], h.pcross);
        check($sformatf("d%0d_tag", d), otag[d], h.tag);
      end else if (fresh[d]) begin
        check($sformatf("d%0d_reset_outs", d), {oaddr[d], otag[d], owrap[d], opc[d]}, 0);
      end
      dc = (d == 0) ? dcnt0 : {14'd0, dcnt1};
      check($sformatf("d%0d_done_cnt", d), dc, mdone[d]);
      acc_f[d] = 1'b0;
      xfr_f[d] = 1'b0;
      if (rst) begin
        mc[d] = 0; mh[d] = 0; mdone[d] = 0; fresh[d] = 1'b1;
      end else begin
        if (e_ov && ordy) begin
          mh[d] = (mh[d] + 1) % 16; mc[d]--; mdone[d] = (mdone[d] + 1) & mask; xfr_f[d] = 1'b1;
        end
        if (flush) begin
          mc[d] = 0;
        end else if (e_ir && iv[d]) begin
          e = ref_ea(pc, base, ir, a1, a2, tag);
          e.acc = cyc_n;
          mq[d][(mh[d] + mc[d]) % 16] = e;
          mc[d]++; acc_f[d] = 1'b1; fresh[d] = 1'b0;
        end
      end
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pay();
    pc = 16'($urandom); base = 16'($urandom); ir = 16'($urandom);
    a1 = 1'($urandom); a2 = 2'($urandom); tag = 4'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic stream(input int d, input int n, input int p_ordy, input int p_flush);
    int sent;
    sent = 0;
    rand_pay();
    iv[d] = 1'b1;
    for (int g = 0; g < 400 && sent < n; g++) begin
      ordy  = ($urandom_range(0, 99) < p_ordy);
      flush = ($urandom_range(0, 99) < p_flush);
      cyc();
      if (acc_f[d]) begin sent++; rand_pay(); end
    end
    iv[d] = 1'b0; flush = 1'b0;
  endtask

  initial begin
    int k, sent;
    int seq [5] = '{1, 2, 3, 0, 1};
    iv[0] = 1'b0; iv[1] = 1'b0;
    @(posedge clk); #1;
    do_reset();
    idle(1);

    // Test 1: PC + field B (0x1FF = -1), latency 2
    pc = 16'h3000; ir = 16'h01FF; a1 = 1'b0; a2 = 2'd2; tag = 4'h5; ordy = 1'b1; iv[0] = 1'b1;
    cyc(); iv[0] = 1'b0;
    check("t1_lat1_valid", ov[0], 0);
    cyc();
    check("t1_valid", ov[0], 1);
    check("t1_addr", oaddr[0], 16'h2FFF);
    check("t1_wrap", owrap[0], 1);
    check("t1_pcross", opc[0], 1);
    idle(2);

    // Test 2: base 0xFFFF + field A (+1), then + zero
    base = 16'hFFFF; ir = 16'h0001; a1 = 1'b1; a2 = 2'd1; iv[0] = 1'b1;
    cyc(); a2 = 2'd0;
    cyc(); iv[0] = 1'b0;
    check("t2a_addr", oaddr[0], 16'h0000);
    check("t2a_wrap", owrap[0], 1);
    check("t2a_pcross", opc[0], 1);
    cyc();
    check("t2b_addr", oaddr[0], 16'hFFFF);
    check("t2b_wrap", owrap[0], 0);
    check("t2b_pcross", opc[0], 0);
    idle(2);

    // Test 3: consumer stalled 6 cycles, 4 back-to-back requests
    ordy = 1'b0; rand_pay(); tag = 4'd0; iv[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (acc_f[0]) begin tag = tag + 4'd1; pc = pc + 16'd3; end
    end
    check("t3_accepted", tag, 2);
    check("t3_blocked", irdy[0], 0);
    ordy = 1'b1;
    for (int g = 0; g < 20 && tag < 4'd4; g++) begin
      cyc();
      if (acc_f[0]) begin tag = tag + 4'd1; pc = pc + 16'd3; end
    end
    check("t3_all_accepted", tag, 4);
    iv[0] = 1'b0;
    idle(4);

    // Test 4: stream of 8 then a flush with the pipe full
    stream(0, 8, 100, 0);
    iv[0] = 1'b1; ordy = 1'b1;
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0; iv[0] = 1'b0;
    check("t4_flushed_valid", ov[0], 0);
    idle(5);

    // Test 5: reset pulse mid-stream, then a single request
    stream(0, 5, 100, 0);
    iv[0] = 1'b1;
    cyc();
    do_reset();
    iv[0] = 1'b0;
    check("t5_valid", ov[0], 0);
    check("t5_done", dcnt0, 0);
    check("t5_addr", oaddr[0], 0);
    rand_pay(); iv[0] = 1'b1;
    cyc(); iv[0] = 1'b0;
    check("t5_lat1_valid", ov[0], 0);
    cyc();
    check("t5_lat2_valid", ov[0], 1);
    idle(3);

    // Test 6: 4-stage instance, field C 0x400 -> offset 0xFC00, 2-bit counter wraps
    do_reset();
    pc = 16'h0000; ir = 16'h0400; a1 = 1'b0; a2 = 2'd3; tag = 4'h9; ordy = 1'b1; iv[1] = 1'b1;
    cyc(); iv[1] = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check("t6_latency_valid", ov[1], 0);
      cyc();
    end
    check("t6_valid", ov[1], 1);
    check("t6_addr", oaddr[1], 16'hFC00);
    check("t6_pcross", opc[1], 1);
    check("t6_done0", dcnt1, 0);
    k = 0; sent = 0;
    rand_pay(); iv[1] = 1'b1;
    for (int g = 0; g < 20 && k < 5; g++) begin
      cyc();
      if (acc_f[1]) begin
        sent++;
        if (sent == 4) iv[1] = 1'b0;
        else rand_pay();
      end
      if (xfr_f[1]) begin
        check("t6_done_seq", dcnt1, seq[k]);
        k++;
      end
    end
    check("t6_transfers", k, 5);
    iv[1] = 1'b0;
    idle(3);

    // Randomized traffic with backpressure and occasional flushes on both depths
    for (int r = 0; r < 6; r++) begin
      stream(0, 30, $urandom_range(30, 100), 3);
      ordy = 1'b1; idle(5);
      stream(1, 30, $urandom_range(30, 100), 3);
      ordy = 1'b1; idle(7);
      if (r == 3) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
